mst_mch_fifo_ctl: RTL and testbench
===================================

Name: mst_mch_fifo_ctl

Overview:
Parametrised multi-channel FIFO controller for the FT600 master FIFO datapath. It partitions one shared dual-port memory into NCH equal circular channel buffers. The block sits between the master FIFO FSM / prefetch logic and the buffer memory. New versus the current 4-channel controller: generic channel count, width and depth, programmable almost-full gap, per-channel flush, overflow/underflow status, and automatic re-partition when the mode strap changes.

Parameters:
NCH, 4, channel count; power of two, at least 2; CW = clog2(NCH).
DW, 36, word width (32 data + 4 byte-enable).
AW, 14, total memory address bits; channel depth CD = 2^AW/NCH when mltcn=1, 2^AW when mltcn=0.
AFULL_GAP, 4, fifoafull[c] asserts when count >= depth - AFULL_GAP.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  reset; asynchronous assert, active-low.
mltcn  in  1  mode: 1 = multi-channel, 0 = 245 mode (channel 0 only).
fifowr  in  1  write request.
fifowrid  in  CW  channel to write.
fifo_din  in  DW  write data.
fiford  in  1  read request.
fifordid  in  CW  channel to read.
flush  in  NCH  per-channel flush pulse.
fifo_dout  out  DW  read data (combinational from mem_q).
fifo_dval  out  1  fifo_dout valid.
fifonempt  out  NCH  channel not empty.
fifoafull  out  NCH  channel almost full.
fifoovf  out  NCH  sticky: write to full channel.
fifoudf  out  NCH  sticky: read from empty channel.
mem_we  out  1  memory write enable.
mem_wa  out  AW  memory write address.
mem_d  out  DW  memory write data.
mem_ra  out  AW  memory read address.
mem_q  in  DW  memory read data; 1-cycle synchronous read latency.

Behaviour:
- Reset values: all flags 0, fifo_dval 0, mem_we 0, mem_wa/mem_ra/mem_d 0, all pointers and counts 0.
- Per-channel state: wr_ptr and rd_ptr, each AW bits; count of AW+1 bits, range 0..depth.
- Address mapping:
  - mltcn=1: address = {ch, ptr[AW-CW-1:0]}.
  - mltcn=0: address = ptr[AW-1:0] for channel 0.
  - Pointers wrap modulo depth.
- Write is accepted when fifowr=1 and count[fifowrid] < depth.
  - Same cycle: mem_we=1, mem_wa = mapped wr_ptr, mem_d = fifo_din.
  - The pointer increments at the clock edge.
- Read is accepted when fiford=1 and count[fifordid] > 0.
  - Same cycle: mem_ra = mapped rd_ptr.
  - Next cycle: fifo_dval=1 and fifo_dout = mem_q.
  - The pointer increments at the clock edge.
- Count update:
  - Accepted write only: +1.
  - Accepted read only: -1.
  - Both on the same channel: unchanged.
  - Reads and writes on different channels are fully concurrent.
- Flags are registered and reflect counts after the edge: fifonempt = count>0; fifoafull = count >= depth-AFULL_GAP.
- Write to a full channel:
  - Dropped: mem_we=0, no state change.
  - fifoovf[c] set.
- Read from an empty channel:
  - Ignored: fifo_dval=0 next cycle.
  - fifoudf[c] set.
- 245 mode (mltcn=0):
  - Channels 1..NCH-1 hold fifoafull=1 and fifonempt=0.
  - Writes to them are dropped and set fifoovf; reads from them set fifoudf.
- flush[c]:
  - Clears pointers, count, fifoovf[c] and fifoudf[c] at the edge.
  - Wins over a coincident read or write on c; that write is suppressed (mem_we=0) and that read gives no fifo_dval.
  - Other channels are unaffected.
- mltcn is sampled every cycle. Any change, detected on the registered value, acts as flush of all channels in the following cycle. Requests in that cycle are dropped without setting ovf/udf.
- Reset mid-operation: immediate asynchronous clear; an in-flight read produces no fifo_dval.

Decomposition:
- Shared package mst_fifo_pkg:
  - clog2 function.
  - Channel-depth and afull-threshold functions of (mltcn, AW, NCH, AFULL_GAP).
  - Default DW/AW constants.
- Sub-module mst_ch_ptr: one channel's pointers, count, flags and flush handling. Instantiated NCH times via generate.
- The top level of this block holds request decode, address mux, the fifo_dval pipeline and mltcn change detection.

Test Plan:
All scenarios use NCH=4, AW=6 (depth 16 per channel in mltcn=1), AFULL_GAP=4.
1. Release rst_n, no requests -> fifonempt=0000, fifoafull=0000, mem_we=0, fifo_dval=0.
2. mltcn=1, write 12 words to ch1 -> mem_wa 0x10..0x1B; fifonempt[1]=1 after first write; fifoafull[1]=1 after the edge of the 12th write.
3. Fill ch2 with 16 words, then a 17th write -> 17th has mem_we=0; fifoovf[2]=1; 16 reads return words 1..16 in order from mem_ra 0x20..0x2F; fifonempt[2] clears after the 16th.
4. ch3 holds 5 words; simultaneous read ch3 and write ch3 -> count stays 5; fifo_dval=1 next cycle with word 1; mem_wa=0x35.
5. mltcn=0: write 64 words to ch0, and one write to ch1 -> mem_wa 0x00..0x3F; fifoafull[0] at count 60; ch1 write dropped with fifoovf[1]=1.
6. ch1 holds 3 words; flush[1] with a coincident write to ch1 -> write suppressed; fifonempt[1]=0; fifoovf[1]=0.
7. Then toggle mltcn -> all channels empty two cycles later.

Source files
------------

// File: rtl/mst_fifo_pkg.sv
// mst_fifo_pkg: shared constants and sizing helpers for the multi-channel FIFO controller
package mst_fifo_pkg;

    localparam int DEF_DW = 36;
    localparam int DEF_AW = 14;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ch_depth(input logic mltcn, input int aw, input int nch);
        return mltcn ? (1 << aw) / nch : (1 << aw);
    endfunction

    function automatic int afull_thr(input logic mltcn, input int aw, input int nch, input int gap);
        return ch_depth(mltcn, aw, nch) - gap;
    endfunction

endpackage

// File: rtl/mst_ch_ptr.sv
// mst_ch_ptr: one channel's circular pointers, occupancy count, status flags and flush
module mst_ch_ptr
    import mst_fifo_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [AW:0]   i_depth,
    input  logic [AW:0]   i_thr,
    input  logic          i_wr,
    input  logic          i_rd,
    input  logic          i_flush,
    output logic          o_wr_ok,
    output logic          o_rd_ok,
    output logic [AW-1:0] o_wr_ptr,
    output logic [AW-1:0] o_rd_ptr,
    output logic          o_nempt,
    output logic          o_afull,
    output logic          o_ovf,
    output logic          o_udf
);

    logic [AW:0]   r_cnt;
    logic [AW-1:0] r_wp, r_rp;
    logic          w_full, w_empty;
    logic [AW-1:0] w_mask;
    logic [AW:0]   w_cnt_nx;

    // A disabled channel looks permanently full and empty, so every request on it faults
    always_comb begin
        w_full   = !i_en || (r_cnt >= i_depth);
        w_empty  = !i_en || (r_cnt == '0);
        o_wr_ok  = i_wr && !w_full && !i_flush;
        o_rd_ok  = i_rd && !w_empty && !i_flush;
        w_mask   = i_depth[AW-1:0] - AW'(1);
        w_cnt_nx = i_flush ? '0 : r_cnt + (AW+1)'(o_wr_ok) - (AW+1)'(o_rd_ok);
        o_wr_ptr = r_wp;
        o_rd_ptr = r_rp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            o_nempt <= 1'b0;
            o_afull <= 1'b0;
            o_ovf   <= 1'b0;
            o_udf   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nx;
            r_wp    <= i_flush ? '0 : o_wr_ok ? (r_wp + AW'(1)) & w_mask : r_wp;
            r_rp    <= i_flush ? '0 : o_rd_ok ? (r_rp + AW'(1)) & w_mask : r_rp;
            o_nempt <= i_en && (w_cnt_nx != '0);
            o_afull <= !i_en || (w_cnt_nx >= i_thr);
            o_ovf   <= !i_flush && (o_ovf || (i_wr && w_full));
            o_udf   <= !i_flush && (o_udf || (i_rd && w_empty));
        end
    end

endmodule

// File: rtl/mst_mch_fifo_ctl.sv
// mst_mch_fifo_ctl: partitions one shared memory into NCH circular channel FIFOs;
// request decode, address mapping, read-valid pipeline and mode-change flush.
module mst_mch_fifo_ctl
    import mst_fifo_pkg::*;
#(
    parameter  int NCH       = 4,
    parameter  int DW        = DEF_DW,
    parameter  int AW        = DEF_AW,
    parameter  int AFULL_GAP = 4,
    localparam int CW        = clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mltcn,
    input  logic           fifowr,
    input  logic [CW-1:0]  fifowrid,
    input  logic [DW-1:0]  fifo_din,
    input  logic           fiford,
    input  logic [CW-1:0]  fifordid,
    input  logic [NCH-1:0] flush,
    output logic [DW-1:0]  fifo_dout,
    output logic           fifo_dval,
    output logic [NCH-1:0] fifonempt,
    output logic [NCH-1:0] fifoafull,
    output logic [NCH-1:0] fifoovf,
    output logic [NCH-1:0] fifoudf,
    output logic           mem_we,
    output logic [AW-1:0]  mem_wa,
    output logic [DW-1:0]  mem_d,
    output logic [AW-1:0]  mem_ra,
    input  logic [DW-1:0]  mem_q
);

    logic           r_mltcn, r_chg, r_dval;
    logic [AW:0]    w_depth, w_thr;
    logic [NCH-1:0] w_wr, w_rd, w_flush, w_wr_ok, w_rd_ok;
    logic [AW-1:0]  w_wp [NCH];
    logic [AW-1:0]  w_rp [NCH];

    function automatic logic [AW-1:0] map_addr(input logic m, input logic [CW-1:0] ch,
                                               input logic [AW-1:0] p);
        return m ? {ch, p[AW-CW-1:0]} : p;
    endfunction

    always_comb begin
        w_depth = (AW+1)'(ch_depth(r_mltcn, AW, NCH));
        w_thr   = (AW+1)'(afull_thr(r_mltcn, AW, NCH, AFULL_GAP));
    end

    // The cycle after a mode change flushes every channel and swallows all requests
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_wr[c]    = rst_n && fifowr && (fifowrid == CW'(c)) && !r_chg;
        assign w_rd[c]    = rst_n && fiford && (fifordid == CW'(c)) && !r_chg;
        assign w_flush[c] = flush[c] || r_chg;
        mst_ch_ptr #(.AW(AW)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (r_mltcn || (c == 0)),
            .i_depth  (w_depth),
            .i_thr    (w_thr),
            .i_wr     (w_wr[c]),
            .i_rd     (w_rd[c]),
            .i_flush  (w_flush[c]),
            .o_wr_ok  (w_wr_ok[c]),
            .o_rd_ok  (w_rd_ok[c]),
            .o_wr_ptr (w_wp[c]),
            .o_rd_ptr (w_rp[c]),
            .o_nempt  (fifonempt[c]),
            .o_afull  (fifoafull[c]),
            .o_ovf    (fifoovf[c]),
            .o_udf    (fifoudf[c])
        );
    end

    always_comb begin
        mem_we    = |w_wr_ok;
        mem_wa    = mem_we ? map_addr(r_mltcn, fifowrid, w_wp[fifowrid]) : '0;
        mem_d     = mem_we ? fifo_din : '0;
        mem_ra    = (|w_rd_ok) ? map_addr(r_mltcn, fifordid, w_rp[fifordid]) : '0;
        fifo_dout = mem_q;
        fifo_dval = r_dval;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mltcn <= 1'b1;
            r_chg   <= 1'b0;
            r_dval  <= 1'b0;
        end else begin
            r_mltcn <= mltcn;
            r_chg   <= mltcn != r_mltcn;
            r_dval  <= |w_rd_ok;
        end
    end

endmodule

// File: tb/tb_mst_mch_fifo_ctl.sv
// tb_mst_mch_fifo_ctl: directed scoreboard bench; stimulus queues expected writes and
// read data, a negedge monitor pops and compares whenever mem_we or fifo_dval appears.
module tb_mst_mch_fifo_ctl;

    logic        clk, rst_n, mltcn, fifowr, fiford, fifo_dval, mem_we;
    logic [1:0]  fifowrid, fifordid;
    logic [35:0] fifo_din, fifo_dout, mem_d, mem_q;
    logic [3:0]  flush, fifonempt, fifoafull, fifoovf, fifoudf;
    logic [5:0]  mem_wa, mem_ra;
    logic [35:0] mem [64];
    logic [41:0] wq [$];
    logic [35:0] rq [$];
    int total = 0;
    int bad = 0;

    mst_mch_fifo_ctl #(.NCH(4), .DW(36), .AW(6), .AFULL_GAP(4)) dut (
        .clk(clk), .rst_n(rst_n), .mltcn(mltcn), .fifowr(fifowr), .fifowrid(fifowrid),
        .fifo_din(fifo_din), .fiford(fiford), .fifordid(fifordid), .flush(flush),
        .fifo_dout(fifo_dout), .fifo_dval(fifo_dval), .fifonempt(fifonempt),
        .fifoafull(fifoafull), .fifoovf(fifoovf), .fifoudf(fifoudf), .mem_we(mem_we),
        .mem_wa(mem_wa), .mem_d(mem_d), .mem_ra(mem_ra), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_q = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_d;
        mem_q <= mem[mem_ra];
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [35:0] word(input int c, input int i);
        return {4'hF, 8'(c), 24'(i)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (wq.size() == 0) chk("unexpected_write", {22'b0, mem_wa, mem_d}, 64'h0);
                else chk("write_addr_data", {22'b0, mem_wa, mem_d}, {22'b0, wq.pop_front()});
            end
            if (fifo_dval) begin
                if (rq.size() == 0) chk("unexpected_dval", {28'b0, fifo_dout}, 64'h0);
                else chk("read_data", {28'b0, fifo_dout}, {28'b0, rq.pop_front()});
            end
        end
    end

    task automatic op(input bit w, input int wc, input logic [35:0] wdat, input bit wok, input int wa,
                      input bit r, input int rc, input bit rok, input int ra, input logic [35:0] rdat,
                      input logic [3:0] fl);
        fifowr = w; fifowrid = 2'(wc); fifo_din = wdat;
        fiford = r; fifordid = 2'(rc); flush = fl;
        if (wok) wq.push_back({6'(wa), wdat});
        if (rok) rq.push_back(rdat);
        #1;
        chk("mem_we", 64'(mem_we), 64'(wok));
        if (rok) chk("mem_ra", 64'(mem_ra), 64'(ra));
        @(posedge clk); #1;
        fifowr = 1'b0; fiford = 1'b0; flush = '0;
    endtask

    task automatic wr(input int c, input int i, input bit ok, input int a);
        op(1, c, word(c, i), ok, a, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic rd(input int c, input bit ok, input int a, input int i);
        op(0, 0, '0, 0, 0, 1, c, ok, a, word(c, i), '0);
    endtask

    task automatic idle();
        op(0, 0, '0, 0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0; mltcn = 1'b1; fifowr = 1'b0; fiford = 1'b0;
        fifowrid = '0; fifordid = '0; fifo_din = '0; flush = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_nempt", 64'(fifonempt), 64'h0);
        chk("rst_afull", 64'(fifoafull), 64'h0);
        chk("rst_ovf", 64'(fifoovf), 64'h0);
        chk("rst_mem_we", 64'(mem_we), 64'h0);
        chk("rst_dval", 64'(fifo_dval), 64'h0);
        @(posedge clk); #1;
        idle();
        chk("idle_afull", 64'(fifoafull), 64'h0);

        for (int i = 0; i < 12; i++) begin
            wr(1, i, 1, 'h10 + i);
            if (i == 0) chk("ch1_nempt_first", 64'(fifonempt[1]), 64'h1);
            if (i == 10) chk("ch1_afull_11", 64'(fifoafull[1]), 64'h0);
        end
        chk("ch1_afull_12", 64'(fifoafull[1]), 64'h1);

        for (int i = 0; i < 16; i++) wr(2, i, 1, 'h20 + i);
        wr(2, 16, 0, 0);
        chk("ch2_ovf", 64'(fifoovf[2]), 64'h1);
        for (int i = 0; i < 16; i++) begin
            rd(2, 1, 'h20 + i, i);
            if (i == 14) chk("ch2_nempt_15", 64'(fifonempt[2]), 64'h1);
        end
        chk("ch2_nempt_16", 64'(fifonempt[2]), 64'h0);
        rd(2, 0, 0, 0);
        chk("ch2_udf", 64'(fifoudf[2]), 64'h1);

        for (int i = 0; i < 5; i++) wr(3, i, 1, 'h30 + i);
        op(1, 3, word(3, 5), 1, 'h35, 1, 3, 1, 'h30, word(3, 0), '0);
        for (int i = 1; i < 6; i++) rd(3, 1, 'h30 + i, i);
        chk("ch3_empty", 64'(fifonempt[3]), 64'h0);
        rd(3, 0, 0, 0);
        chk("ch3_udf", 64'(fifoudf[3]), 64'h1);

        op(0, 0, '0, 0, 0, 0, 0, 0, 0, '0, 4'b0010);
        chk("ch1_flush_nempt", 64'(fifonempt[1]), 64'h0);
        chk("ch1_flush_afull", 64'(fifoafull[1]), 64'h0);
        for (int i = 0; i < 3; i++) wr(1, 20 + i, 1, 'h10 + i);
        chk("ch1_three", 64'(fifonempt[1]), 64'h1);
        op(1, 1, word(1, 30), 0, 0, 1, 1, 0, 0, '0, 4'b0110);
        chk("flush_nempt1", 64'(fifonempt[1]), 64'h0);
        chk("flush_ovf", 64'(fifoovf), 64'h0);
        chk("flush_udf", 64'(fifoudf), 64'b1000);
        wr(1, 31, 1, 'h10);
        rd(1, 1, 'h10, 31);

        mltcn = 1'b0;
        idle();
        wr(0, 99, 0, 0);
        chk("m0_nempt", 64'(fifonempt), 64'h0);
        chk("m0_afull", 64'(fifoafull), 64'b1110);
        chk("m0_ovf", 64'(fifoovf), 64'h0);
        for (int i = 0; i < 64; i++) begin
            wr(0, i, 1, i);
            if (i == 58) chk("ch0_afull_59", 64'(fifoafull[0]), 64'h0);
            if (i == 59) chk("ch0_afull_60", 64'(fifoafull[0]), 64'h1);
        end
        wr(0, 64, 0, 0);
        wr(1, 0, 0, 0);
        chk("m0_ovf_01", 64'(fifoovf), 64'b0011);
        rd(1, 0, 0, 0);
        chk("m0_udf1", 64'(fifoudf[1]), 64'h1);
        rd(0, 1, 'h00, 0);
        rd(0, 1, 'h01, 1);

        mltcn = 1'b1;
        idle();
        wr(0, 0, 0, 0);
        chk("m1_nempt", 64'(fifonempt), 64'h0);
        chk("m1_afull", 64'(fifoafull), 64'h0);
        chk("m1_flags", 64'({fifoovf, fifoudf}), 64'h0);

        wr(0, 7, 1, 'h00);
        fiford = 1'b1; fifordid = 2'd0;
        #1 chk("inflight_ra", 64'(mem_ra), 64'h0);
        @(posedge clk); #1;
        fiford = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_dval_kill", 64'(fifo_dval), 64'h0);
        chk("rst_nempt_mid", 64'(fifonempt), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) idle();
        chk("wq_drained", 64'(wq.size()), 64'h0);
        chk("rq_drained", 64'(rq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
